mem_access_ctrl: RTL
====================

# mem_access_ctrl

Parametrised, multi-channel memory access controller for the OSECPU core. Each request carries a label's base, count and type plus a pointer offset and access type. The block arbitrates between NUM_CH requesters round-robin and checks bounds and type. It then issues the physical access to a single memory port and returns the read data or a fault code to the requester. It sits between the pointer-register/label-table read stage and the data memory, replacing the combinational base+offset adder.

## Interface
Parameters:
- NUM_CH, 2: number of request channels (1..8)
- ADDR_W, 16: width of base, ofs, count, addr
- DATA_W, 32: memory data width
- TYPE_W, 8: width of label type / request type
- CH_W, $clog2(NUM_CH) (min 1): channel id width

Ports (per-channel fields are packed vectors, channel i at slice i):
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_CH  request present
- req_ready  out  NUM_CH  request accepted this cycle
- req_base  in  NUM_CH*ADDR_W  label base address
- req_ofs  in  NUM_CH*ADDR_W  pointer offset (unsigned)
- req_count  in  NUM_CH*ADDR_W  label element count
- req_lbtype  in  NUM_CH*TYPE_W  label type from label table
- req_type  in  NUM_CH*TYPE_W  type the instruction expects
- req_we  in  NUM_CH  1 = write
- req_wdata  in  NUM_CH*DATA_W  write data
- mem_valid  out  1  memory command valid
- mem_ready  in  1  memory accepts command
- mem_addr  out  ADDR_W  physical address
- mem_we  out  1  write enable
- mem_wdata  out  DATA_W  write data
- mem_rvalid  in  1  read data valid (reads only)
- mem_rdata  in  DATA_W  read data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_ch  out  CH_W  channel the response belongs to
- rsp_fault  out  2  fault code (FAULT_* in package)
- rsp_rdata  out  DATA_W  read data (0 for writes/faults)

## Operation
- FSM states: IDLE, CHECK, MEM_CMD, MEM_WAIT, RESP. The block holds one transaction at a time.
- IDLE: the round-robin grant picks the first valid channel starting at last_grant+1, mod NUM_CH. req_ready for that channel only is driven combinationally. The handshake occurs when req_valid&req_ready. The block then captures all fields and the channel id, updates last_grant, and moves to CHECK.
- CHECK (1 cycle): sum = base + ofs computed at ADDR_W+1 bits.
  - FAULT_BOUNDS if ofs >= count or sum carries out.
  - Otherwise FAULT_TYPE if req_type != lbtype.
  - Otherwise FAULT_NONE.
  - Bounds takes priority over type.
  - count = 0 always faults on bounds.
  - Next state is MEM_CMD on FAULT_NONE and RESP on any fault. No memory access is made on a fault.
- MEM_CMD: mem_valid=1 with addr=sum[ADDR_W-1:0], we and wdata stable until mem_ready.
  - On handshake, a write goes to RESP and a read goes to MEM_WAIT.
- MEM_WAIT: the first cycle with mem_rvalid=1 latches mem_rdata and goes to RESP. mem_rvalid in any other state is ignored.
- RESP: rsp_valid=1 and all rsp_* are stable until rsp_ready. On handshake, go to IDLE.
- Reset (async, any state) aborts the transaction: every output is deasserted immediately, with no partial command retained.

## Timing
- Reset values:
  - req_ready=0 (combinational, IDLE-gated), mem_valid=0, rsp_valid=0.
  - mem_addr=0, mem_we=0, mem_wdata=0, rsp_ch=0, rsp_fault=0, rsp_rdata=0.
  - last_grant=NUM_CH-1, so channel 0 wins first.
- Faulting request: accept at edge T, CHECK at T+1, rsp_valid from T+2.
- Write with mem_ready tied 1: accept at T, mem_valid in cycle T+2, rsp_valid from T+3.
- Read: rsp_valid appears one cycle after the mem_rvalid cycle.
- Minimum issue interval is 4 cycles (write) or 5 cycles (zero-latency read).
- A requester holding req_valid is served within NUM_CH transactions; there is no starvation.
- req_ready is never asserted outside IDLE.
- There is no combinational path from mem_* inputs or rsp_ready to any output.

## Structure
- Shared package (def.v-style defines, extended):
  - FAULT_NONE=2'b00, FAULT_BOUNDS=2'b01, FAULT_TYPE=2'b10.
  - FSM state encodings.
  - The existing LBTYPE_* codes.
- One sub-module: rr_arbiter (NUM_CH requests, last-grant pointer in, one-hot grant plus index out). The arbiter is purely combinational; the pointer register lives in mem_access_ctrl.

## Test plan
- Write in bounds: NUM_CH=2, ch0 base=2, ofs=2, count=6, type=lbtype=LBTYPE_CODE, we=1, wdata=0xA5.
  - Required: mem_addr=4, mem_we=1, rsp_fault=00, rsp_ch=0, rsp_valid 3 cycles after accept.
- Bounds fault: base=2, ofs=6, count=6.
  - Required: no mem_valid ever; rsp_fault=01, rsp_valid at T+2.
- Overflow plus type mismatch: base=0xFFFF, ofs=1, count=8, type mismatch.
  - Required: rsp_fault=01, bounds beating type.
- Type fault: base=2, ofs=1, count=6, req_type=lbtype+1.
  - Required: rsp_fault=10.
- Read with latency and backpressure: mem_ready low 3 cycles, mem_rvalid 2 cycles later with rdata=0x1234, rsp_ready low 2 cycles.
  - Required: mem_* held stable throughout, rsp_rdata=0x1234 stable until consumed.
- Fairness and reset: both channels valid continuously.
  - Required: grants alternate 0,1,0,1.
  - Assert rst_n=0 mid-MEM_CMD: mem_valid drops the same cycle, and the first grant after release is ch0.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the memory access controller: fault codes, FSM states, label types.
package mem_access_ctrl_pkg;

    // Fault codes returned with every response
    localparam logic [1:0] FAULT_NONE   = 2'b00;
    localparam logic [1:0] FAULT_BOUNDS = 2'b01;
    localparam logic [1:0] FAULT_TYPE   = 2'b10;

    // Controller FSM; one transaction in flight at a time
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        MEM_CMD  = 3'd2,
        MEM_WAIT = 3'd3,
        RESP     = 3'd4
    } state_e;

    // Label type codes as stored in the label table
    localparam logic [7:0] LBTYPE_UNDEF  = 8'h00;
    localparam logic [7:0] LBTYPE_CODE   = 8'h01;
    localparam logic [7:0] LBTYPE_VPTR   = 8'h02;
    localparam logic [7:0] LBTYPE_SINT8  = 8'h03;
    localparam logic [7:0] LBTYPE_SINT16 = 8'h04;
    localparam logic [7:0] LBTYPE_SINT32 = 8'h05;
    localparam logic [7:0] LBTYPE_DATA   = 8'h06;

endpackage

// File: rtl/mem_access_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant wins.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CH_W   = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic [NUM_CH-1:0] gnt_oh,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    int unsigned     cand;
    logic [CH_W-1:0] cand_idx;

    // Scan channels last_grant+1 .. last_grant+NUM_CH (mod NUM_CH), keep the first hit
    always_comb begin
        gnt_oh   = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand     = (32'(last_grant) + k) % NUM_CH;
            cand_idx = CH_W'(cand);
            if (!gnt_any && req[cand_idx]) begin
                gnt_any          = 1'b1;
                gnt_idx          = cand_idx;
                gnt_oh[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-channel memory access controller: arbitrate, bounds/type check, single memory port.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TYPE_W = 8,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*ADDR_W-1:0] req_base,
    input  logic [NUM_CH*ADDR_W-1:0] req_ofs,
    input  logic [NUM_CH*ADDR_W-1:0] req_count,
    input  logic [NUM_CH*TYPE_W-1:0] req_lbtype,
    input  logic [NUM_CH*TYPE_W-1:0] req_type,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_rvalid,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [CH_W-1:0]          rsp_ch,
    output logic [1:0]               rsp_fault,
    output logic [DATA_W-1:0]        rsp_rdata
);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     last_grant_q, last_grant_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [ADDR_W-1:0]   base_q, base_d, ofs_q, ofs_d, count_q, count_d;
    logic [TYPE_W-1:0]   lbtype_q, lbtype_d, rtype_q, rtype_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [CH_W-1:0]     rsp_ch_q, rsp_ch_d;
    logic [1:0]          rsp_fault_q, rsp_fault_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [NUM_CH-1:0]   gnt_oh;
    logic [CH_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic [ADDR_W:0]     sum_c;
    logic [1:0]          fault_c;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt_oh     (gnt_oh),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    // Ready only in IDLE and never while reset is applied
    assign req_ready = ((state_q == IDLE) && rst_n) ? gnt_oh : '0;

    // Extra bit catches address wrap-around
    assign sum_c = {1'b0, base_q} + {1'b0, ofs_q};

    // Bounds beats type; count of zero always trips the ofs >= count test
    always_comb begin
        fault_c = FAULT_NONE;
        if ((ofs_q >= count_q) || sum_c[ADDR_W]) begin
            fault_c = FAULT_BOUNDS;
        end else if (rtype_q != lbtype_q) begin
            fault_c = FAULT_TYPE;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= CH_W'(NUM_CH - 1);
            ch_q         <= '0;
            base_q       <= '0;
            ofs_q        <= '0;
            count_q      <= '0;
            lbtype_q     <= '0;
            rtype_q      <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_ch_q     <= '0;
            rsp_fault_q  <= FAULT_NONE;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ch_q         <= ch_d;
            base_q       <= base_d;
            ofs_q        <= ofs_d;
            count_q      <= count_d;
            lbtype_q     <= lbtype_d;
            rtype_q      <= rtype_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_ch_q     <= rsp_ch_d;
            rsp_fault_q  <= rsp_fault_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ch_d         = ch_q;
        base_d       = base_q;
        ofs_d        = ofs_q;
        count_d      = count_q;
        lbtype_d     = lbtype_q;
        rtype_d      = rtype_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_ch_d     = rsp_ch_q;
        rsp_fault_d  = rsp_fault_q;
        rsp_rdata_d  = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (gnt_oh[i]) begin
                            base_d   = req_base[i*ADDR_W +: ADDR_W];
                            ofs_d    = req_ofs[i*ADDR_W +: ADDR_W];
                            count_d  = req_count[i*ADDR_W +: ADDR_W];
                            lbtype_d = req_lbtype[i*TYPE_W +: TYPE_W];
                            rtype_d  = req_type[i*TYPE_W +: TYPE_W];
                            we_d     = req_we[i];
                            wdata_d  = req_wdata[i*DATA_W +: DATA_W];
                        end
                    end
                    ch_d         = gnt_idx;
                    last_grant_d = gnt_idx;
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                if (fault_c != FAULT_NONE) begin
                    rsp_valid_d = 1'b1;
                    rsp_ch_d    = ch_q;
                    rsp_fault_d = fault_c;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = sum_c[ADDR_W-1:0];
                    mem_we_d    = we_q;
                    mem_wdata_d = wdata_q;
                    state_d     = MEM_CMD;
                end
            end
            MEM_CMD: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (we_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_ch_d    = ch_q;
                        rsp_fault_d = FAULT_NONE;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_rvalid) begin
                    rsp_valid_d = 1'b1;
                    rsp_ch_d    = ch_q;
                    rsp_fault_d = FAULT_NONE;
                    rsp_rdata_d = mem_rdata;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ch    = rsp_ch_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
